// File: rtl/latch_sched_pkg.sv
// Shared definitions for the latch write scheduler.
//   state_e        : scheduler FSM states
//   DEF_WIDTH      : default latch word width
//   DEF_DEPTH      : default number of latch words
//   DEF_EN_CYCLES  : default latch-enable pulse length in cycles
//   CNT_W          : width of the enable-phase counter (covers 1..15)
package latch_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ENABLE = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_DEPTH     = 4;
   localparam int DEF_EN_CYCLES = 2;
   localparam int CNT_W         = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock and synchronous active-high reset
//   req      : request from requester 0 / 1
//   advance  : high when the caller accepts the current grant
//   grant    : one-hot grant (combinational)
//   index    : index of the granted requester (combinational)
// After reset requester 0 holds priority; each accepted grant hands priority
// to the other requester.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       index
);

   logic prio_q;
   logic prio_d;

   always_comb begin
      grant  = 2'b00;
      index  = 1'b0;
      if (prio_q == 1'b0) begin
         if (req[0]) begin
            grant = 2'b01;
            index = 1'b0;
         end else if (req[1]) begin
            grant = 2'b10;
            index = 1'b1;
         end
      end else begin
         if (req[1]) begin
            grant = 2'b10;
            index = 1'b1;
         end else if (req[0]) begin
            grant = 2'b01;
            index = 1'b0;
         end
      end
      prio_d = prio_q;
      if (advance && (|req)) begin
         prio_d = ~index;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/latch_write_scheduler.sv
// Schedules writes from two requesters into an external bank of latch words.
//   clk, rst     : clock and synchronous active-high reset
//   req[1:0]     : write request per requester, held until its ack
//   addr0/addr1  : target word of requester 0 / 1
//   data0/data1  : write data of requester 0 / 1
//   ack[1:0]     : one-cycle completion pulse per requester
//   busy         : transaction in progress
//   gnt_id       : current owner (valid while busy)
//   lat_d        : shared D bus to all latch words
//   lat_e        : one-hot latch enables
// A transaction is SETUP (data on bus), ENABLE for EN_CYCLES cycles, then
// HOLD (enable low, data still stable, ack). All outputs are registered and
// are computed from the next state so they line up with the state they
// belong to.
module latch_write_scheduler
   import latch_sched_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int EN_CYCLES = DEF_EN_CYCLES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               req,
   input  logic [$clog2(DEPTH)-1:0] addr0,
   input  logic [$clog2(DEPTH)-1:0] addr1,
   input  logic [WIDTH-1:0]         data0,
   input  logic [WIDTH-1:0]         data1,
   output logic [1:0]               ack,
   output logic                     busy,
   output logic                     gnt_id,
   output logic [WIDTH-1:0]         lat_d,
   output logic [DEPTH-1:0]         lat_e
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EN_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gnt_id_q, gnt_id_d;
   logic [1:0]       ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [DEPTH-1:0] lat_e_q, lat_e_d;
   logic [WIDTH-1:0] lat_d_q, lat_d_d;
   logic [AW-1:0]    addr_q, addr_d;

   logic [1:0]       arb_grant;
   logic             arb_index;
   logic             arb_advance;

   // Arbitration is only consumed in IDLE; elsewhere requests are ignored.
   assign arb_advance = (state_q == ST_IDLE);

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (arb_advance),
      .grant   (arb_grant),
      .index   (arb_index)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_id_d = gnt_id_q;
      addr_d   = addr_q;
      lat_d_d  = lat_d_q;
      ack_d    = 2'b00;
      lat_e_d  = '0;

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               state_d  = ST_SETUP;
               gnt_id_d = arb_index;
               // lat_d_q doubles as the captured data register.
               addr_d   = arb_grant[1] ? addr1 : addr0;
               lat_d_d  = arb_grant[1] ? data1 : data0;
            end
         end
         ST_SETUP: begin
            state_d = ST_ENABLE;
            cnt_d   = '0;
         end
         ST_ENABLE: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      if (state_d == ST_ENABLE) begin
         lat_e_d[addr_d] = 1'b1;
      end
      if (state_d == ST_HOLD) begin
         ack_d[gnt_id_d] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gnt_id_q <= 1'b0;
         ack_q    <= 2'b00;
         busy_q   <= 1'b0;
         lat_e_q  <= '0;
         lat_d_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_id_q <= gnt_id_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         lat_e_q  <= lat_e_d;
         lat_d_q  <= lat_d_d;
      end
   end

   // Captured address is only meaningful while busy, so it needs no reset.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
   end

   assign ack    = ack_q;
   assign busy   = busy_q;
   assign gnt_id = gnt_id_q;
   assign lat_d  = lat_d_q;
   assign lat_e  = lat_e_q;

endmodule

// File: tb/tb_latch_write_scheduler.sv
// Directed bench for latch_write_scheduler: a default instance (EN_CYCLES=2)
// and an EN_CYCLES=1 instance, each driving a small latch-word load model.
module tb_latch_write_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] req = 2'b00;
   logic [1:0] req_b = 2'b00;
   logic [1:0] addr0 = 2'd0;
   logic [1:0] addr1 = 2'd0;
   logic [7:0] data0 = 8'h00;
   logic [7:0] data1 = 8'h00;

   logic [1:0] ack, ack_b;
   logic       busy, busy_b;
   logic       gnt_id, gnt_id_b;
   logic [7:0] lat_d, lat_d_b;
   logic [3:0] lat_e, lat_e_b;

   logic [7:0] mem   [4];
   logic [7:0] mem_b [4];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   latch_write_scheduler #(.WIDTH(8), .DEPTH(4), .EN_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
      .data0(data0), .data1(data1), .ack(ack), .busy(busy),
      .gnt_id(gnt_id), .lat_d(lat_d), .lat_e(lat_e)
   );

   latch_write_scheduler #(.WIDTH(8), .DEPTH(4), .EN_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .req(req_b), .addr0(addr0), .addr1(addr1),
      .data0(data0), .data1(data1), .ack(ack_b), .busy(busy_b),
      .gnt_id(gnt_id_b), .lat_d(lat_d_b), .lat_e(lat_e_b)
   );

   // Latch-word load: a word takes the bus value while its enable is high.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (lat_e[i]) mem[i] <= lat_d;
         if (lat_e_b[i]) mem_b[i] <= lat_d_b;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ticks until an ack appears (bounded), then checks latency, ack and owner.
   task automatic run_txn(input string tag, input logic [1:0] exp_ack,
                          input logic exp_gnt, input int exp_lat, input logic drop);
      int n = 0;
      do begin
         tick();
         n++;
      end while (ack == 2'b00 && n < 20);
      chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
      chk({tag, "_gnt"}, 32'(gnt_id), 32'(exp_gnt));
      if (drop) req = req & ~ack;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_lat_e", 32'(lat_e), 32'd0);
      chk("rst_lat_d", 32'(lat_d), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_gnt", 32'(gnt_id), 32'd0);

      // Single write, cycle by cycle
      addr0 = 2'd2; data0 = 8'hA5; req = 2'b01;
      tick();
      chk("sw_setup_busy", 32'(busy), 32'd1);
      chk("sw_setup_lat_e", 32'(lat_e), 32'd0);
      chk("sw_setup_lat_d", 32'(lat_d), 32'hA5);
      tick();
      chk("sw_en1_lat_e", 32'(lat_e), 32'b0100);
      tick();
      chk("sw_en2_lat_e", 32'(lat_e), 32'b0100);
      chk("sw_en2_ack", 32'(ack), 32'd0);
      tick();
      chk("sw_hold_ack", 32'(ack), 32'b01);
      chk("sw_hold_lat_e", 32'(lat_e), 32'd0);
      chk("sw_hold_busy", 32'(busy), 32'd1);
      req = 2'b00;
      tick();
      chk("sw_idle_busy", 32'(busy), 32'd0);
      chk("sw_idle_ack", 32'(ack), 32'd0);
      chk("sw_idle_lat_d", 32'(lat_d), 32'hA5);
      chk("sw_word2", 32'(mem[2]), 32'hA5);

      // Simultaneous requests after reset: 0 first, then 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_lat_d", 32'(lat_d), 32'd0);
      addr0 = 2'd1; data0 = 8'h11; addr1 = 2'd3; data1 = 8'h22; req = 2'b11;
      run_txn("sim_a", 2'b01, 1'b0, 4, 1'b1);
      run_txn("sim_b", 2'b10, 1'b1, 5, 1'b1);
      tick();
      chk("sim_word1", 32'(mem[1]), 32'h11);
      chk("sim_word3", 32'(mem[3]), 32'h22);

      // Continuous requests: grants alternate 0,1,0,1
      addr0 = 2'd0; data0 = 8'h5A; addr1 = 2'd2; data1 = 8'h6B; req = 2'b11;
      run_txn("rr0", 2'b01, 1'b0, 4, 1'b0);
      run_txn("rr1", 2'b10, 1'b1, 5, 1'b0);
      run_txn("rr2", 2'b01, 1'b0, 5, 1'b0);
      run_txn("rr3", 2'b10, 1'b1, 5, 1'b0);
      tick();
      chk("rr_ack_one_cycle", 32'(ack), 32'd0);
      req = 2'b00;
      tick();
      chk("rr_word0", 32'(mem[0]), 32'h5A);
      chk("rr_word2", 32'(mem[2]), 32'h6B);

      // Inputs change after grant (req dropped too): transaction unaffected
      addr0 = 2'd1; data0 = 8'h3C; req = 2'b01;
      tick();
      chk("cap_setup_lat_d", 32'(lat_d), 32'h3C);
      tick();
      data0 = 8'hFF; addr0 = 2'd3; req = 2'b00;
      chk("cap_en1_lat_e", 32'(lat_e), 32'b0010);
      tick();
      chk("cap_en2_lat_d", 32'(lat_d), 32'h3C);
      chk("cap_en2_lat_e", 32'(lat_e), 32'b0010);
      tick();
      chk("cap_hold_ack", 32'(ack), 32'b01);
      tick();
      chk("cap_word1", 32'(mem[1]), 32'h3C);
      chk("cap_word3", 32'(mem[3]), 32'h22);

      // Reset in ENABLE cycle 2 aborts; priority returns to requester 0
      addr0 = 2'd0; data0 = 8'h77; req = 2'b01;
      tick();
      tick();
      tick();
      chk("ab_en2_lat_e", 32'(lat_e), 32'b0001);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 2'b00;
      chk("ab_lat_e", 32'(lat_e), 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      chk("ab_ack", 32'(ack), 32'd0);
      tick();
      tick();
      chk("ab_no_ack", 32'(ack), 32'd0);
      chk("ab_idle_busy", 32'(busy), 32'd0);
      addr0 = 2'd2; data0 = 8'h81; addr1 = 2'd3; data1 = 8'h82; req = 2'b11;
      run_txn("ab_rr", 2'b01, 1'b0, 4, 1'b1);
      run_txn("ab_rr2", 2'b10, 1'b1, 5, 1'b1);
      tick();

      // EN_CYCLES=1 instance: one enable cycle, ack at cycle 3
      addr0 = 2'd2; data0 = 8'h99; req_b = 2'b01;
      tick();
      chk("e1_setup_lat_e", 32'(lat_e_b), 32'd0);
      chk("e1_setup_lat_d", 32'(lat_d_b), 32'h99);
      tick();
      chk("e1_en_lat_e", 32'(lat_e_b), 32'b0100);
      chk("e1_en_ack", 32'(ack_b), 32'd0);
      tick();
      chk("e1_hold_lat_e", 32'(lat_e_b), 32'd0);
      chk("e1_hold_ack", 32'(ack_b), 32'b01);
      req_b = 2'b00;
      tick();
      chk("e1_idle_busy", 32'(busy_b), 32'd0);
      chk("e1_word2", 32'(mem_b[2]), 32'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
